dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 (core

---
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with core priority and port-1 starvation guard
//
// Purpose: shares one sync-read dmem port between port 0 (core load/store)
// and port 1 (debug/DMA). Port 0 wins contention unless port 1 has been
// blocked STARVE_LIMIT consecutive cycles, in which case port 1 is forced.
// Read data returns one cycle after the accepting strobe on the owning port.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   p0_*/p1_* valid/we/addr/wdata request side of each requester
//   p0_*/p1_* ready/rvalid/rdata  accept strobe and read return per port
//   mem_en/we/addr/wdata/rdata    dmem interface (rdata valid 1 cycle after read)
//   starve_o                      forced port-1 grant in effect this cycle
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          p0_valid_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_ready_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,
    input  logic          p1_valid_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_ready_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          starve_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] wait_cnt;
    logic [1:0]    rd_owner;   // {p1 read, p0 read} accepted last cycle
    logic          force_p1;
    logic          grant0;
    logic          grant1;

    // Grants are gated by rst_ni so nothing is accepted or strobed while in reset.
    always_comb begin
        force_p1 = 1'b0;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (rst_ni) begin
            force_p1 = p1_valid_i && (wait_cnt == LIMIT);
            grant1   = force_p1 || (!p0_valid_i && p1_valid_i);
            grant0   = p0_valid_i && !force_p1;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant1) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p1_we_i;
            mem_addr_o  = p1_addr_i;
            mem_wdata_o = p1_wdata_i;
        end else if (grant0) begin
            mem_en_o    = 1'b1;
            mem_we_o    = p0_we_i;
            mem_addr_o  = p0_addr_i;
            mem_wdata_o = p0_wdata_i;
        end
    end

    assign p0_ready_o = grant0;
    assign p1_ready_o = grant1;
    assign starve_o   = force_p1;

    // The rst_ni gate suppresses the return of a read accepted just before reset.
    assign p0_rvalid_o = rst_ni && rd_owner[0];
    assign p1_rvalid_o = rst_ni && rd_owner[1];
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
            rd_owner <= 2'b00;
        end else begin
            if (!p1_valid_i || grant1) begin
                wait_cnt <= '0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            rd_owner <= {grant1 && !p1_we_i, grant0 && !p0_we_i};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       p0_valid_i, p0_we_i;
    logic [7:0] p0_addr_i, p0_wdata_i;
    logic       p0_ready_o, p0_rvalid_o;
    logic [7:0] p0_rdata_o;
    logic       p1_valid_i, p1_we_i;
    logic [7:0] p1_addr_i, p1_wdata_i;
    logic       p1_ready_o, p1_rvalid_o;
    logic [7:0] p1_rdata_o;
    logic       mem_en_o, mem_we_o;
    logic [7:0] mem_addr_o, mem_wdata_o;
    logic [7:0] mem_rdata_i;
    logic       starve_o;

    int total = 0;
    int fails = 0;

    // Bench-side dmem: sync read, 1-cycle latency, with a preload port.
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en_o && mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_en_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
    end

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_valid_i(p0_valid_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_ready_o(p0_ready_o),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_valid_i(p1_valid_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_ready_o(p1_ready_o),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .starve_o(starve_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        p0_valid_i = v0; p0_we_i = w0; p0_addr_i = a0; p0_wdata_i = d0;
        p1_valid_i = v1; p1_we_i = w1; p1_addr_i = a1; p1_wdata_i = d1;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    // Inputs change 1 time unit after the edge; checks happen 2 units later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        next_cycle();
        pl_en = 1'b0;
    endtask

    logic       sel4 [4];
    logic [7:0] adr4 [4];
    logic [7:0] dat4 [4];
    logic       v1_t5 [9];
    logic       g0_prev, g1_prev;
    logic       e0, e1;

    initial begin
        rst_ni = 1'b0;
        idle();
        mem_rdata_i = 8'h00;
        next_cycle();
        preload(8'h05, 8'h0A);
        preload(8'h0B, 8'h00);
        preload(8'h10, 8'h31);
        preload(8'h11, 8'h42);
        preload(8'h12, 8'h53);
        preload(8'h13, 8'h64);

        // Requests during reset must be ignored.
        drive(1, 0, 8'h05, 8'h00, 1, 1, 8'h06, 8'h77);
        settle();
        chk("rst_p0_ready", p0_ready_o, 0);
        chk("rst_p1_ready", p1_ready_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_starve", starve_o, 0);
        chk("rst_p0_rvalid", p0_rvalid_o, 0);
        next_cycle();

        rst_ni = 1'b1;
        idle();
        settle();
        chk("idle_mem_en", mem_en_o, 0);
        chk("idle_mem_addr", mem_addr_o, 0);
        chk("idle_p0_rvalid", p0_rvalid_o, 0);
        next_cycle();

        // 1: solo p0 read
        drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
        settle();
        chk("t1_p0_ready", p0_ready_o, 1);
        chk("t1_mem_en", mem_en_o, 1);
        chk("t1_mem_we", mem_we_o, 0);
        chk("t1_mem_addr", mem_addr_o, 8'h05);
        chk("t1_p1_ready", p1_ready_o, 0);
        next_cycle();
        idle();
        settle();
        chk("t1_p0_rvalid", p0_rvalid_o, 1);
        chk("t1_p0_rdata", p0_rdata_o, 8'h0A);
        chk("t1_p1_rvalid", p1_rvalid_o, 0);
        chk("t1_p1_rdata", p1_rdata_o, 8'h00);
        chk("t1_mem_en_idle", mem_en_o, 0);
        next_cycle();

        // 2: contention, p1 forced every 5th cycle
        g0_prev = 0; g1_prev = 0;
        for (int c = 0; c < 10; c++) begin
            e1 = ((c % 5) == 4);
            e0 = !e1;
            drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h11, 8'h00);
            settle();
            chk($sformatf("t2_p0_ready_%0d", c), p0_ready_o, e0);
            chk($sformatf("t2_p1_ready_%0d", c), p1_ready_o, e1);
            chk($sformatf("t2_starve_%0d", c), starve_o, e1);
            chk($sformatf("t2_mem_addr_%0d", c), mem_addr_o, e1 ? 8'h11 : 8'h10);
            chk($sformatf("t2_p0_rvalid_%0d", c), p0_rvalid_o, g0_prev);
            chk($sformatf("t2_p1_rvalid_%0d", c), p1_rvalid_o, g1_prev);
            chk($sformatf("t2_p0_rdata_%0d", c), p0_rdata_o, g0_prev ? 8'h31 : 8'h00);
            chk($sformatf("t2_p1_rdata_%0d", c), p1_rdata_o, g1_prev ? 8'h42 : 8'h00);
            g0_prev = e0; g1_prev = e1;
            next_cycle();
        end
        idle();
        settle();
        chk("t2_tail_p1_rvalid", p1_rvalid_o, 1);
        chk("t2_tail_p1_rdata", p1_rdata_o, 8'h42);
        chk("t2_tail_p0_rvalid", p0_rvalid_o, 0);
        next_cycle();

        // 3: p1 write then p0 read of the same address
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h0B, 8'h55);
        settle();
        chk("t3_p1_ready", p1_ready_o, 1);
        chk("t3_mem_we", mem_we_o, 1);
        chk("t3_mem_addr", mem_addr_o, 8'h0B);
        chk("t3_mem_wdata", mem_wdata_o, 8'h55);
        next_cycle();
        drive(1, 0, 8'h0B, 8'h00, 0, 0, 8'h00, 8'h00);
        settle();
        chk("t3_p0_ready", p0_ready_o, 1);
        chk("t3_mem_we_rd", mem_we_o, 0);
        chk("t3_p1_rvalid_wr", p1_rvalid_o, 0);
        next_cycle();
        idle();
        settle();
        chk("t3_p0_rvalid", p0_rvalid_o, 1);
        chk("t3_p0_rdata", p0_rdata_o, 8'h55);
        chk("t3_mem_we_idle", mem_we_o, 0);
        next_cycle();

        // 4: alternating back-to-back reads
        sel4[0] = 0; adr4[0] = 8'h12; dat4[0] = 8'h53;
        sel4[1] = 1; adr4[1] = 8'h13; dat4[1] = 8'h64;
        sel4[2] = 0; adr4[2] = 8'h10; dat4[2] = 8'h31;
        sel4[3] = 1; adr4[3] = 8'h11; dat4[3] = 8'h42;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                if (sel4[k]) drive(0, 0, 8'h00, 8'h00, 1, 0, adr4[k], 8'h00);
                else         drive(1, 0, adr4[k], 8'h00, 0, 0, 8'h00, 8'h00);
            end else begin
                idle();
            end
            settle();
            if (k < 4) begin
                chk($sformatf("t4_p0_ready_%0d", k), p0_ready_o, !sel4[k]);
                chk($sformatf("t4_p1_ready_%0d", k), p1_ready_o, sel4[k]);
            end
            if (k > 0) begin
                chk($sformatf("t4_p0_rvalid_%0d", k), p0_rvalid_o, !sel4[k-1]);
                chk($sformatf("t4_p1_rvalid_%0d", k), p1_rvalid_o, sel4[k-1]);
                chk($sformatf("t4_p0_rdata_%0d", k), p0_rdata_o, sel4[k-1] ? 8'h00 : dat4[k-1]);
                chk($sformatf("t4_p1_rdata_%0d", k), p1_rdata_o, sel4[k-1] ? dat4[k-1] : 8'h00);
            end
            next_cycle();
        end

        // 5: p1 blocked 3, drops 1, then needs 4 more blocked cycles
        v1_t5[0] = 1; v1_t5[1] = 1; v1_t5[2] = 1; v1_t5[3] = 0;
        v1_t5[4] = 1; v1_t5[5] = 1; v1_t5[6] = 1; v1_t5[7] = 1; v1_t5[8] = 1;
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 8'h10, 8'h00, v1_t5[k], 0, 8'h11, 8'h00);
            settle();
            chk($sformatf("t5_p1_ready_%0d", k), p1_ready_o, k == 8);
            chk($sformatf("t5_p0_ready_%0d", k), p0_ready_o, k != 8);
            chk($sformatf("t5_starve_%0d", k), starve_o, k == 8);
            next_cycle();
        end
        idle();
        next_cycle();

        // 6: reset the cycle after a p0 read accept
        drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
        settle();
        chk("t6_p0_ready", p0_ready_o, 1);
        next_cycle();
        rst_ni = 1'b0;
        drive(1, 0, 8'h05, 8'h00, 1, 0, 8'h11, 8'h00);
        settle();
        chk("t6_p0_rvalid", p0_rvalid_o, 0);
        chk("t6_p0_rdata", p0_rdata_o, 8'h00);
        chk("t6_mem_en", mem_en_o, 0);
        chk("t6_mem_we", mem_we_o, 0);
        chk("t6_p0_ready_rst", p0_ready_o, 0);
        chk("t6_p1_ready_rst", p1_ready_o, 0);
        chk("t6_starve", starve_o, 0);
        next_cycle();
        rst_ni = 1'b1;
        idle();
        settle();
        chk("t6_post_p0_rvalid", p0_rvalid_o, 0);
        chk("t6_post_p1_rvalid", p1_rvalid_o, 0);
        chk("t6_post_mem_en", mem_en_o, 0);
        chk("t6_post_mem_addr", mem_addr_o, 8'h00);
        chk("t6_post_starve", starve_o, 0);
        next_cycle();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
